// File: rtl/recorder_pkg.sv
// recorder_pkg: shared types and the speed-setting step rule for the lab3 recorder control core.
package recorder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd1,
        PLAY   = 3'd2,
        RECORD = 3'd3,
        PAUSE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FAST   = 2'd1,
        SLOW   = 2'd2
    } speed_stat_t;

    localparam logic [3:0] SPEED_MIN = 4'd2;
    localparam logic [3:0] SPEED_MAX = 4'd8;

    typedef struct packed {
        speed_stat_t stat;
        logic [3:0]  speed;
    } speed_cfg_t;

    localparam speed_cfg_t SPEED_NORMAL = '{stat: NORMAL, speed: 4'd1};

    // Decoded effect of this cycle's winning key in the current state.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_IDLE,
        ACT_SAVE_IDLE,
        ACT_REC,
        ACT_PLAY,
        ACT_PAUSE,
        ACT_RESUME
    } action_t;

    // Up and down pressed together cancel out.
    function automatic speed_cfg_t speed_next(speed_cfg_t cur, logic up, logic down);
        speed_cfg_t nxt;
        nxt = cur;
        if (up && !down) begin
            case (cur.stat)
                NORMAL:  nxt = '{stat: FAST, speed: SPEED_MIN};
                FAST:    if (cur.speed < SPEED_MAX) nxt.speed = cur.speed + 4'd1;
                SLOW:    if (cur.speed == SPEED_MIN) nxt = SPEED_NORMAL;
                         else nxt.speed = cur.speed - 4'd1;
                default: nxt = SPEED_NORMAL;
            endcase
        end else if (down && !up) begin
            case (cur.stat)
                NORMAL:  nxt = '{stat: SLOW, speed: SPEED_MIN};
                SLOW:    if (cur.speed < SPEED_MAX) nxt.speed = cur.speed + 4'd1;
                FAST:    if (cur.speed == SPEED_MIN) nxt = SPEED_NORMAL;
                         else nxt.speed = cur.speed - 4'd1;
                default: nxt = SPEED_NORMAL;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/recorder_sec_tick.sv
// recorder_sec_tick: sub-second accumulator; frac advances by the speed-dependent step and
// sec_tick pulses (combinationally) in the cycle the accumulator crosses TICK_CYCLES.
module recorder_sec_tick
    import recorder_pkg::*;
#(
    parameter int TICK_CYCLES = 12_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  speed_cfg_t cfg,
    input  logic       run,
    input  logic       clear,
    input  logic       sub_clear,
    output logic       sec_tick
);

    localparam int FW = $clog2(TICK_CYCLES + 8);
    localparam logic [FW-1:0] TICK_V = FW'(TICK_CYCLES);

    logic [FW-1:0] frac;
    logic [FW-1:0] step;
    logic [FW-1:0] sum;
    logic [3:0]    sub;
    logic          sub_hit;

    // NOTE: every variable assigned in always_comb gets a value on all paths, so no latch is inferred.
    always_comb begin
        sub_hit = (sub == cfg.speed - 4'd1);
        case (cfg.stat)
            FAST:    step = FW'(cfg.speed);
            SLOW:    step = FW'(sub_hit);
            default: step = FW'(1);
        endcase
    end

    assign sum      = frac + step;
    assign sec_tick = run && (sum >= TICK_V);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst || clear) begin
            frac <= '0;
            sub  <= 4'd0;
        end else begin
            if (run) frac <= sec_tick ? sum - TICK_V : sum;
            if (sub_clear) sub <= 4'd0;
            else if (run && cfg.stat == SLOW) sub <= sub_hit ? 4'd0 : sub + 4'd1;
        end
    end

endmodule

// File: rtl/recorder_ctrl.sv
// recorder_ctrl: recorder mode FSM, elapsed-seconds timer and playback speed setting.
// Define LOOP_PLAY_EN to restart playback at the end instead of returning to IDLE.
module recorder_ctrl
    import recorder_pkg::*;
#(
    parameter int TICK_CYCLES = 12_000_000,
    parameter int MAX_SEC     = 31
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_play,
    input  logic       i_key_rec,
    input  logic       i_key_pause,
    input  logic       i_key_stop,
    input  logic       i_speed_up,
    input  logic       i_speed_down,
    output logic [4:0] o_timer,
    output logic [2:0] o_state,
    output logic [1:0] o_speed_stat,
    output logic [3:0] o_speed,
    output logic [4:0] o_rec_len,
    output logic       o_play_en,
    output logic       o_rec_en
);

    state_t     state;
    state_t     resume;
    logic [4:0] timer;
    logic [4:0] rec_len;
    logic [4:0] limit;
    speed_cfg_t cfg;
    speed_cfg_t cfg_n;
    speed_cfg_t cfg_tick;
    action_t    act;
    logic       w_stop, w_rec, w_play, w_pause;
    logic       run, clear, done, sec_tick, sub_clear;

    always_comb begin
        w_stop  = i_key_stop;
        w_rec   = i_key_rec && !i_key_stop;
        w_play  = i_key_play && !i_key_stop && !i_key_rec;
        w_pause = i_key_pause && !i_key_stop && !i_key_rec && !i_key_play;
        act     = ACT_NONE;
        case (state)
            IDLE: begin
                if (w_rec) act = ACT_REC;
                else if (w_play && rec_len != 5'd0) act = ACT_PLAY;
            end
            RECORD: begin
                if (w_stop) act = ACT_SAVE_IDLE;
                else if (w_pause) act = ACT_PAUSE;
            end
            PLAY: begin
                if (w_stop) act = ACT_IDLE;
`ifndef LOOP_PLAY_EN
                else if (w_pause) act = ACT_PAUSE;
`endif
            end
            PAUSE: begin
                if (w_stop) act = (resume == RECORD) ? ACT_SAVE_IDLE : ACT_IDLE;
                else if (w_play || w_pause) act = ACT_RESUME;
            end
            default: act = ACT_IDLE;
        endcase
    end

    // Recording always counts at normal rate regardless of the playback speed setting.
    assign cfg_n     = speed_next(cfg, i_speed_up, i_speed_down);
    assign sub_clear = (cfg_n != cfg);
    assign cfg_tick  = (state == RECORD) ? SPEED_NORMAL : cfg;
    assign run       = (state == RECORD || state == PLAY) && act == ACT_NONE;
    assign limit     = (state == RECORD) ? 5'(MAX_SEC) : rec_len;
    assign done      = sec_tick && (timer + 5'd1 == limit);
    assign clear     = (act inside {ACT_IDLE, ACT_SAVE_IDLE, ACT_REC, ACT_PLAY}) || done;

    recorder_sec_tick #(.TICK_CYCLES(TICK_CYCLES)) u_sec_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .cfg       (cfg_tick),
        .run       (run),
        .clear     (clear),
        .sub_clear (sub_clear),
        .sec_tick  (sec_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            resume    <= IDLE;
            timer     <= 5'd0;
            rec_len   <= 5'd0;
            cfg       <= SPEED_NORMAL;
            o_play_en <= 1'b0;
            o_rec_en  <= 1'b0;
        end else begin
            cfg <= cfg_n;
            case (act)
                ACT_REC: begin
                    state     <= RECORD;
                    timer     <= 5'd0;
                    o_rec_en  <= 1'b1;
                    o_play_en <= 1'b0;
                end
                ACT_PLAY: begin
                    state     <= PLAY;
                    timer     <= 5'd0;
                    o_play_en <= 1'b1;
                    o_rec_en  <= 1'b0;
                end
                ACT_IDLE, ACT_SAVE_IDLE: begin
                    if (act == ACT_SAVE_IDLE) rec_len <= timer;
                    state     <= IDLE;
                    timer     <= 5'd0;
                    o_play_en <= 1'b0;
                    o_rec_en  <= 1'b0;
                end
                ACT_PAUSE: begin
                    resume    <= state;
                    state     <= PAUSE;
                    o_play_en <= 1'b0;
                    o_rec_en  <= 1'b0;
                end
                ACT_RESUME: begin
                    state     <= resume;
                    o_play_en <= (resume == PLAY);
                    o_rec_en  <= (resume == RECORD);
                end
                default: begin
                    if (sec_tick) begin
                        if (!done) begin
                            timer <= timer + 5'd1;
                        end else if (state == RECORD) begin
                            rec_len  <= 5'(MAX_SEC);
                            state    <= IDLE;
                            timer    <= 5'd0;
                            o_rec_en <= 1'b0;
                        end else begin
`ifdef LOOP_PLAY_EN
                            timer <= 5'd0;
`else
                            state     <= IDLE;
                            timer     <= 5'd0;
                            o_play_en <= 1'b0;
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign o_timer      = timer;
    assign o_state      = state;
    assign o_speed_stat = cfg.stat;
    assign o_speed      = cfg.speed;
    assign o_rec_len    = rec_len;

endmodule

// File: tb/tb_recorder_ctrl.sv
// tb_recorder_ctrl: directed scenarios plus random key traffic, every cycle compared
// against a cycle-level reference model of the recorder behaviour.
module tb_recorder_ctrl;

    localparam int TICK = 16;
    localparam int MAXS = 31;

    localparam logic [5:0] K_STOP  = 6'b100000;
    localparam logic [5:0] K_REC   = 6'b010000;
    localparam logic [5:0] K_PLAY  = 6'b001000;
    localparam logic [5:0] K_PAUSE = 6'b000100;
    localparam logic [5:0] K_UP    = 6'b000010;
    localparam logic [5:0] K_DOWN  = 6'b000001;

    logic       i_clk, i_rst;
    logic       i_key_play, i_key_rec, i_key_pause, i_key_stop, i_speed_up, i_speed_down;
    logic [4:0] o_timer, o_rec_len;
    logic [2:0] o_state;
    logic [1:0] o_speed_stat;
    logic [3:0] o_speed;
    logic       o_play_en, o_rec_en;

    recorder_ctrl #(.TICK_CYCLES(TICK), .MAX_SEC(MAXS)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_key_play   (i_key_play),
        .i_key_rec    (i_key_rec),
        .i_key_pause  (i_key_pause),
        .i_key_stop   (i_key_stop),
        .i_speed_up   (i_speed_up),
        .i_speed_down (i_speed_down),
        .o_timer      (o_timer),
        .o_state      (o_state),
        .o_speed_stat (o_speed_stat),
        .o_speed      (o_speed),
        .o_rec_len    (o_rec_len),
        .o_play_en    (o_play_en),
        .o_rec_en     (o_rec_en)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: state 1 idle, 2 play, 3 record, 4 pause; speed as a signed rate position.
    int m_state, m_resume, m_timer, m_frac, m_cnt, m_rec_len, m_pos;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_idle();
        m_state = 1;
        m_timer = 0;
        m_frac  = 0;
        m_cnt   = 0;
    endtask

    task automatic model_start(input int st);
        m_state = st;
        m_timer = 0;
        m_frac  = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step(input logic [5:0] k);
        int  win, step, npos;
        bit  acted;
        win   = k[5] ? 1 : k[4] ? 2 : k[3] ? 3 : k[2] ? 4 : 0;
        acted = 1'b1;
        if (m_state == 1 && win == 2) model_start(3);
        else if (m_state == 1 && win == 3 && m_rec_len != 0) model_start(2);
        else if (m_state == 3 && win == 1) begin m_rec_len = m_timer; model_idle(); end
        else if (m_state == 3 && win == 4) begin m_resume = 3; m_state = 4; end
        else if (m_state == 2 && win == 1) model_idle();
`ifndef LOOP_PLAY_EN
        else if (m_state == 2 && win == 4) begin m_resume = 2; m_state = 4; end
`endif
        else if (m_state == 4 && win == 1) begin
            if (m_resume == 3) m_rec_len = m_timer;
            model_idle();
        end
        else if (m_state == 4 && (win == 3 || win == 4)) m_state = m_resume;
        else acted = 1'b0;

        if (!acted && (m_state == 2 || m_state == 3)) begin
            if (m_state == 3 || m_pos == 0) step = 1;
            else if (m_pos > 0) step = m_pos + 1;
            else begin
                // slow: one unit per (speed) cycles
                m_cnt++;
                step = (m_cnt == 1 - m_pos) ? 1 : 0;
                if (step == 1) m_cnt = 0;
            end
            m_frac += step;
            if (m_frac >= TICK) begin
                m_frac -= TICK;
                m_timer++;
                if (m_state == 3 && m_timer == MAXS) begin m_rec_len = MAXS; model_idle(); end
                else if (m_state == 2 && m_timer == m_rec_len) begin
`ifdef LOOP_PLAY_EN
                    m_timer = 0;
                    m_frac  = 0;
`else
                    model_idle();
`endif
                end
            end
        end

        if (k[1] != k[0]) begin
            npos = k[1] ? m_pos + 1 : m_pos - 1;
            if (npos > 7) npos = 7;
            if (npos < -7) npos = -7;
            if (npos != m_pos) m_cnt = 0;
            m_pos = npos;
        end
    endtask

    task automatic compare_all();
        int exp_stat, exp_speed;
        exp_stat  = (m_pos == 0) ? 0 : (m_pos > 0) ? 1 : 2;
        exp_speed = (m_pos == 0) ? 1 : (m_pos > 0) ? m_pos + 1 : 1 - m_pos;
        check("state", 32'(o_state), m_state);
        check("timer", 32'(o_timer), m_timer);
        check("rec_len", 32'(o_rec_len), m_rec_len);
        check("speed_stat", 32'(o_speed_stat), exp_stat);
        check("speed", 32'(o_speed), exp_speed);
        check("play_en", 32'(o_play_en), (m_state == 2) ? 1 : 0);
        check("rec_en", 32'(o_rec_en), (m_state == 3) ? 1 : 0);
    endtask

    task automatic cycle(input logic [5:0] k);
        @(negedge i_clk);
        {i_key_stop, i_key_rec, i_key_play, i_key_pause, i_speed_up, i_speed_down} = k;
        @(posedge i_clk);
        model_step(k);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(6'b0);
    endtask

    initial begin
        logic [5:0] k;
        i_rst = 1'b1;
        {i_key_stop, i_key_rec, i_key_play, i_key_pause, i_speed_up, i_speed_down} = 6'b0;
        m_state = 1; m_resume = 1; m_timer = 0; m_frac = 0; m_cnt = 0; m_rec_len = 0; m_pos = 0;

        // 1. reset
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_state", 32'(o_state), 1);
        check("rst_timer", 32'(o_timer), 0);
        check("rst_stat", 32'(o_speed_stat), 0);
        check("rst_speed", 32'(o_speed), 1);
        check("rst_rec_len", 32'(o_rec_len), 0);
        check("rst_en", 32'({o_play_en, o_rec_en}), 0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // 2. three-second recording
        cycle(K_REC);
        check("t2_rec_en", 32'(o_rec_en), 1);
        idle(48);
        check("t2_timer3", 32'(o_timer), 3);
        cycle(K_STOP);
        check("t2_state", 32'(o_state), 1);
        check("t2_rec_len", 32'(o_rec_len), 3);

        // 3. normal playback to the end
        cycle(K_PLAY);
        check("t3_state", 32'(o_state), 2);
        check("t3_play_en", 32'(o_play_en), 1);
        idle(16);
        check("t3_timer1", 32'(o_timer), 1);
        idle(16);
        check("t3_timer2", 32'(o_timer), 2);
        idle(16);
`ifdef LOOP_PLAY_EN
        check("t3_loop_timer", 32'(o_timer), 0);
        check("t3_loop_state", 32'(o_state), 2);
`else
        check("t3_end_state", 32'(o_state), 1);
`endif
        cycle(K_STOP);

        // 4. fast playback and saturation
        repeat (3) cycle(K_UP);
        check("t4_stat", 32'(o_speed_stat), 1);
        check("t4_speed4", 32'(o_speed), 4);
        cycle(K_PLAY);
        idle(4);
        check("t4_fast_timer", 32'(o_timer), 1);
        cycle(K_STOP);
        repeat (10) cycle(K_UP);
        check("t4_speed8", 32'(o_speed), 8);
        repeat (7) cycle(K_DOWN);
        check("t4_back_stat", 32'(o_speed_stat), 0);
        check("t4_back_speed", 32'(o_speed), 1);

        // 5. slow playback and cancelled up+down
        cycle(K_DOWN);
        check("t5_stat", 32'(o_speed_stat), 2);
        check("t5_speed", 32'(o_speed), 2);
        cycle(K_PLAY);
        idle(31);
        check("t5_timer_before", 32'(o_timer), 0);
        idle(1);
        check("t5_timer1", 32'(o_timer), 1);
        cycle(K_STOP);
        cycle(K_UP | K_DOWN);
        check("t5_both_stat", 32'(o_speed_stat), 2);
        check("t5_both_speed", 32'(o_speed), 2);
        cycle(K_UP);

        // 6. maximum-length recording, pause/resume, stop beats rec
        cycle(K_REC);
        idle(31 * 16 - 1);
        check("t6_timer30", 32'(o_timer), 30);
        idle(1);
        check("t6_auto_idle", 32'(o_state), 1);
        check("t6_rec_len31", 32'(o_rec_len), 31);
        cycle(K_REC);
        idle(5 * 16);
        cycle(K_PAUSE);
        idle(100);
        check("t6_pause_timer", 32'(o_timer), 5);
        check("t6_pause_state", 32'(o_state), 4);
        cycle(K_PLAY);
        check("t6_resume_state", 32'(o_state), 3);
        cycle(K_STOP | K_REC);
        check("t6_stop_wins", 32'(o_state), 1);
        check("t6_rec_len5", 32'(o_rec_len), 5);

        // random key traffic against the model
        for (int i = 0; i < 4000; i++) begin
            k = 6'b0;
            if ($urandom_range(0, 59) == 0) k |= K_STOP;
            if ($urandom_range(0, 39) == 0) k |= K_REC;
            if ($urandom_range(0, 24) == 0) k |= K_PLAY;
            if ($urandom_range(0, 39) == 0) k |= K_PAUSE;
            if ($urandom_range(0, 49) == 0) k |= K_UP;
            if ($urandom_range(0, 49) == 0) k |= K_DOWN;
            cycle(k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
